// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer: arbitrates ALU (req0) and load (req1) write-backs onto the single
// register-file write port, driving a registered SETUP/STROBE/HOLD sequence on rf_regwrite.
// Ports: clk/reset (async, active-high); reqN_valid/rd/data in, reqN_ready out;
// rf_wr/rf_wd/rf_regwrite to the register file; pend_valid/pend_addr for hazard stalls;
// wr_count counts strobed writes.
module regfile_wb_sequencer #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int CNT_W      = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_rd,
    input  logic [XLEN-1:0]  req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_rd,
    input  logic [XLEN-1:0]  req1_data,
    output logic             req1_ready,
    output logic [AW-1:0]    rf_wr,
    output logic [XLEN-1:0]  rf_wd,
    output logic             rf_regwrite,
    output logic             pend_valid,
    output logic [AW-1:0]    pend_addr,
    output logic [CNT_W-1:0] wr_count
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    state_t state, state_n;
    logic last_grant, open, win0, t0, t1, go;
    logic [AW-1:0] xrd;
    logic [XLEN-1:0] xd;
    always_comb begin
        open       = state == IDLE || state == HOLD;
        win0       = FIXED_PRIO != 0 ? 1'b1 : last_grant;
        req0_ready = open & (!req1_valid | win0);
        req1_ready = open & (!req0_valid | !win0);
        t0         = req0_valid & req0_ready;
        t1         = req1_valid & req1_ready;
        xrd        = t1 ? req1_rd : req0_rd;
        xd         = t1 ? req1_data : req0_data;
        // writes to x0 are consumed without touching the port
        go         = (t0 | t1) && xrd != '0;
        state_n    = state == SETUP ? STROBE : state == STROBE ? HOLD : go ? SETUP : IDLE;
    end
    // strobe is a flop so the file never sees a decode glitch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rf_regwrite <= 1'b0;
            rf_wr       <= '0;
            rf_wd       <= '0;
            pend_valid  <= 1'b0;
            pend_addr   <= '0;
            wr_count    <= '0;
            last_grant  <= 1'b1;
        end else begin
            state       <= state_n;
            rf_regwrite <= state_n == STROBE;
            pend_valid  <= state_n != IDLE;
            if (state_n == STROBE) wr_count <= wr_count + 1'b1;
            if (t0 | t1) last_grant <= t1;
            if (go) begin
                rf_wr     <= xrd;
                rf_wd     <= xd;
                pend_addr <= xrd;
            end
        end
    end
endmodule
